add_16: RTL and testbench

ADD_16 -- requirements
Module: add_16

---
 rtl/add_16_pkg.sv | 19 +
 rtl/add_16_cla4.sv | 52 +++++
 rtl/add_16.sv | 98 +++++++++
 tb/tb_add_16.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/add_16_pkg.sv
// Shared constants and types for the 16-bit carry-lookahead adder.
//
// WIDTH      : operand/sum width (the adder is built for 16 bits only)
// GROUP      : bits handled by one cla4 lookahead group
// NUM_GROUPS : number of cla4 groups that tile the full width
// result_t   : bundle of everything the top registers each clock
package add_16_pkg;

  localparam int WIDTH      = 16;
  localparam int GROUP      = 4;
  localparam int NUM_GROUPS = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

endpackage

// File: rtl/add_16_cla4.sv
// cla4 -- one 4-bit carry-lookahead group.
//
// Produces the 4-bit sum slice for a given carry-in, plus the group
// propagate/generate pair used by the second-level lookahead in add_16.
//
// Ports:
//   a_i, b_i : 4-bit operand slices
//   c_i      : carry into bit 0 of this group
//   s_o      : 4-bit sum slice
//   p_o      : group propagate (carry-in passes through the whole group)
//   g_o      : group generate (group produces a carry on its own)
module cla4
  import add_16_pkg::*;
(
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             c_i,
  output logic [GROUP-1:0] s_o,
  output logic             p_o,
  output logic             g_o
);

  logic [GROUP-1:0] bitP;
  logic [GROUP-1:0] bitG;
  logic [GROUP-1:0] bitC;

  // Per-bit propagate/generate. XOR propagate lets the same signal
  // double as the half-sum.
  always_comb begin
    bitP = a_i ^ b_i;
    bitG = a_i & b_i;
  end

  // Every internal carry is expanded straight from c_i, so no carry
  // ripples from bit to bit inside the group.
  always_comb begin
    bitC[0] = c_i;
    bitC[1] = bitG[0] | (bitP[0] & c_i);
    bitC[2] = bitG[1] | (bitP[1] & bitG[0]) | (bitP[1] & bitP[0] & c_i);
    bitC[3] = bitG[2] | (bitP[2] & bitG[1]) | (bitP[2] & bitP[1] & bitG[0])
            | (bitP[2] & bitP[1] & bitP[0] & c_i);
  end

  // Sum slice and the group terms handed up to the second level.
  always_comb begin
    s_o = bitP ^ bitC;
    p_o = &bitP;
    g_o = bitG[3] | (bitP[3] & bitG[2]) | (bitP[3] & bitP[2] & bitG[1])
        | (bitP[3] & bitP[2] & bitP[1] & bitG[0]);
  end

endmodule

// File: rtl/add_16.sv
// add_16 -- 16-bit two-level carry-lookahead adder with registered copies.
//
// Four cla4 groups feed a second-level lookahead unit that forms the
// group carries directly from cin. sum/cout are purely combinational;
// sum_q/cout_q/ovf_q capture them every rising clk edge.
//
// Ports:
//   clk    : clock, registers update on rising edge
//   rst_n  : asynchronous active-low reset, clears registered outputs only
//   a, b   : unsigned 16-bit addends
//   cin    : carry-in
//   sum    : combinational a+b+cin mod 2^16
//   cout   : combinational carry-out (bit 16 of a+b+cin)
//   sum_q  : registered sum
//   cout_q : registered carry-out
//   ovf_q  : registered two's-complement overflow flag
module add_16 #(
  parameter int WIDTH = add_16_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  import add_16_pkg::*;

  // The lookahead unit below is written out for exactly four groups.
  if (WIDTH != 16) begin : gWidthCheck
    $error("add_16 supports WIDTH=16 only");
  end

  logic [NUM_GROUPS-1:0] groupP;
  logic [NUM_GROUPS-1:0] groupG;
  logic [NUM_GROUPS:0]   groupCarry;
  logic                  carryInto15;
  result_t               result_d;
  result_t               result_q;

  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : gGroup
    cla4 uCla4 (
      .a_i (a[gi*GROUP +: GROUP]),
      .b_i (b[gi*GROUP +: GROUP]),
      .c_i (groupCarry[gi]),
      .s_o (sum[gi*GROUP +: GROUP]),
      .p_o (groupP[gi]),
      .g_o (groupG[gi])
    );
  end

  // Second-level lookahead: each group carry is a flat sum of products
  // of cin and the group P/G terms, never chained through the previous
  // group's carry.
  always_comb begin
    groupCarry[0] = cin;
    groupCarry[1] = groupG[0] | (groupP[0] & cin);
    groupCarry[2] = groupG[1] | (groupP[1] & groupG[0])
                  | (groupP[1] & groupP[0] & cin);
    groupCarry[3] = groupG[2] | (groupP[2] & groupG[1])
                  | (groupP[2] & groupP[1] & groupG[0])
                  | (groupP[2] & groupP[1] & groupP[0] & cin);
    groupCarry[4] = groupG[3] | (groupP[3] & groupG[2])
                  | (groupP[3] & groupP[2] & groupG[1])
                  | (groupP[3] & groupP[2] & groupP[1] & groupG[0])
                  | (groupP[3] & groupP[2] & groupP[1] & groupP[0] & cin);
  end

  assign cout = groupCarry[NUM_GROUPS];

  // The carry into the MSB is recovered from the MSB sum bit itself
  // (s = a ^ b ^ c), which avoids exporting an extra carry from cla4.
  always_comb begin
    carryInto15   = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];
    result_d.sum  = sum;
    result_d.cout = cout;
    result_d.ovf  = carryInto15 ^ cout;
  end

  // Output registers; reset clears them without touching sum/cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign sum_q  = result_q.sum;
  assign cout_q = result_q.cout;
  assign ovf_q  = result_q.ovf;

endmodule

// File: tb/tb_add_16.sv
// tb_add_16 -- self-checking bench for add_16.
//
// A reference model built on plain integer arithmetic predicts both the
// combinational result and the registered copies; one compare process
// checks the DUT against it on every falling edge. Directed vectors with
// hand-worked literal answers pin the model, and a mid-cycle reset
// checks the asynchronous clear.
module tb_add_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] sum_q;
  logic        cout_q;
  logic        ovf_q;

  int vectorCount = 0;
  int missCount   = 0;
  bit checkEn     = 1'b0;

  // Model state for the registered outputs.
  logic [15:0] expSumQ;
  logic        expCoutQ;
  logic        expOvfQ;

  add_16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  // 100 ns clock: rising edges at 50, 150, ...; checks on falling edges.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Full 17-bit unsigned result of a+b+cin.
  function automatic logic [16:0] modelAdd(input logic [15:0] x, input logic [15:0] y,
                                           input logic c);
    int total;
    total = int'(x) + int'(y) + int'(c);
    return total[16:0];
  endfunction

  // Signed overflow: the true signed sum falls outside the 16-bit range.
  function automatic logic modelOvf(input logic [15:0] x, input logic [15:0] y,
                                    input logic c);
    int total;
    total = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (total > 32767) || (total < -32768);
  endfunction

  // Registered-output model: loads on each rising edge while out of reset.
  always @(posedge clk or negedge rst_n) begin
    logic [16:0] r;
    if (!rst_n) begin
      expSumQ  = 16'h0;
      expCoutQ = 1'b0;
      expOvfQ  = 1'b0;
    end else begin
      r        = modelAdd(a, b, cin);
      expSumQ  = r[15:0];
      expCoutQ = r[16];
      expOvfQ  = modelOvf(a, b, cin);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h (a=%h b=%h cin=%b)",
               name, actual, expected, a, b, cin);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                               input logic c);
    @(posedge clk);
    #1;
    a   = x;
    b   = y;
    cin = c;
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("comb_result", {15'b0, cout, sum}, {15'b0, modelAdd(a, b, cin)});
      checkOutput("sum_q", {16'b0, sum_q}, {16'b0, expSumQ});
      checkOutput("cout_q", {31'b0, cout_q}, {31'b0, expCoutQ});
      checkOutput("ovf_q", {31'b0, ovf_q}, {31'b0, expOvfQ});
    end
  end

  initial begin
    a     = 16'h0;
    b     = 16'h0;
    cin   = 1'b0;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    #10;
    checkOutput("reset_sum_q", {16'b0, sum_q}, 32'h0);
    checkOutput("reset_flags", {30'b0, cout_q, ovf_q}, 32'h0);

    // Release reset between edges so the first load is clean.
    #10 rst_n = 1'b1;
    checkEn = 1'b1;

    // a=0, b=0, cin=0
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("zero_comb", {15'b0, cout, sum}, 32'h0);
    @(negedge clk);
    checkOutput("zero_regs", {14'b0, ovf_q, cout_q, sum_q}, 32'h0);

    // Full wrap: FFFF + 0 + 1 = 0x10000, no signed overflow (-1 + 1).
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("wrap_comb", {15'b0, cout, sum}, 32'h0001_0000);
    @(negedge clk);
    checkOutput("wrap_cout_q", {31'b0, cout_q}, 32'h1);
    checkOutput("wrap_ovf_q", {31'b0, ovf_q}, 32'h0);

    // 7FFF + 1 = 8000: positive + positive gives negative.
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    checkOutput("ovf_comb", {15'b0, cout, sum}, 32'h0000_8000);
    @(negedge clk);
    checkOutput("ovf_ovf_q", {31'b0, ovf_q}, 32'h1);
    checkOutput("ovf_sum_q", {16'b0, sum_q}, 32'h0000_8000);

    // Maximum result: FFFF + FFFF + 1 = 131071 = 0x1FFFF.
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    checkOutput("max_comb", {15'b0, cout, sum}, 32'd131071);
    @(negedge clk);
    checkOutput("max_regs", {14'b0, ovf_q, cout_q, sum_q}, 32'h0001_FFFF);

    // 8000 + 8000 = 0x10000: negative + negative overflows.
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("negovf_regs", {14'b0, ovf_q, cout_q, sum_q}, 32'h0003_0000);

    // Random vectors, a new one every rising edge.
    for (int i = 0; i < 250; i++) begin
      applyStimulus(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)));
    end

    // Mid-cycle reset: load 0x1234+0x4321+1 = 0x5556, then pull rst_n low.
    applyStimulus(16'h1234, 16'h4321, 1'b1);
    @(posedge clk);
    #10;
    checkOutput("preload_sum_q", {16'b0, sum_q}, 32'h0000_5556);
    #10 rst_n = 1'b0;
    #5;
    checkOutput("async_clear", {14'b0, ovf_q, cout_q, sum_q}, 32'h0);
    checkOutput("rst_comb", {15'b0, cout, sum}, 32'h0000_5556);
    a = 16'h0F0F;
    #5;
    checkOutput("rst_comb_track", {15'b0, cout, sum}, 32'h0000_5231);
    @(negedge clk);
    #10 rst_n = 1'b1;

    // A few more random vectors after reset release.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
    end
    @(negedge clk);
    checkEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
